rr_logb_beat_aligner: RTL and testbench

RR_LOGB_BEAT_ALIGNER -- requirements
Module: rr_logb_beat_aligner

---
 rtl/rr_logb_beat_aligner.sv | 113 +++++++++++
 tb/tb_rr_logb_beat_aligner.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_logb_beat_aligner.sv
`default_nettype none
// ============================================================================
// Module     : rr_logb_beat_aligner
// Description: Packs variable-length logging-bus words into fixed OUT_WIDTH
//              beats; a flush emits the residual bits as a zero-padded beat.
// Revision   : 1.0 - initial release
// ============================================================================
module rr_logb_beat_aligner #(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 512,
    parameter int LEN_WIDTH = $clog2(IN_WIDTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [IN_WIDTH-1:0]            in_data,
    input  logic [LEN_WIDTH-1:0]           in_len,
    output logic                           in_ready,
    input  logic                           flush,
    output logic                           out_valid,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic [$clog2(OUT_WIDTH+1)-1:0] out_bits,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic                           flush_done,
    output logic [31:0]                    beat_cnt,
    output logic [63:0]                    bit_cnt
);
    localparam int BUF_W  = 2 * OUT_WIDTH;
    localparam int FILL_W = $clog2(BUF_W);
    localparam int BITS_W = $clog2(OUT_WIDTH + 1);
    localparam logic [FILL_W-1:0]    c_OUT_FILL = FILL_W'(OUT_WIDTH);
    localparam logic [LEN_WIDTH-1:0] c_IN_LEN   = LEN_WIDTH'(IN_WIDTH);

    generate
        if (IN_WIDTH > OUT_WIDTH || IN_WIDTH == 0) begin : g_param_check
            $error("rr_logb_beat_aligner: IN_WIDTH must be in 1..OUT_WIDTH");
        end
    endgenerate

    logic [BUF_W-1:0]     r_buf;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_flush_pending;
    logic                 r_flush_done;
    logic [31:0]          r_beat_cnt;
    logic [63:0]          r_bit_cnt;

    logic [LEN_WIDTH-1:0] w_len;
    logic [IN_WIDTH-1:0]  w_mask;
    logic [BUF_W-1:0]     w_ins;
    logic                 w_full;
    logic                 w_pad;
    logic                 w_accept;
    logic                 w_pop;

    // Bits of r_buf at or above r_fill are always zero, so inserts can OR in
    // and the padded tail beat needs no extra masking.
    always_comb begin
        w_len    = (in_len > c_IN_LEN) ? c_IN_LEN : in_len;
        w_mask   = ~({IN_WIDTH{1'b1}} << w_len);
        w_ins    = {{(BUF_W-IN_WIDTH){1'b0}}, in_data & w_mask} << r_fill;
        w_full   = (r_fill >= c_OUT_FILL);
        w_pad    = r_flush_pending && !w_full && (r_fill != '0);
        w_accept = in_valid && in_ready;
        w_pop    = (w_full || w_pad) && out_ready;
    end

    assign in_ready   = !w_full && !r_flush_pending;
    assign out_valid  = w_full || w_pad;
    assign out_data   = out_valid ? r_buf[OUT_WIDTH-1:0] : '0;
    assign out_bits   = w_full ? BITS_W'(OUT_WIDTH) : (w_pad ? BITS_W'(r_fill) : '0);
    assign out_last   = w_pad;
    assign flush_done = r_flush_done;
    assign beat_cnt   = r_beat_cnt;
    assign bit_cnt    = r_bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf           <= '0;
            r_fill          <= '0;
            r_flush_pending <= 1'b0;
            r_flush_done    <= 1'b0;
            r_beat_cnt      <= '0;
            r_bit_cnt       <= '0;
        end else begin
            r_flush_done <= 1'b0;
            if (w_accept) begin
                r_buf     <= r_buf | w_ins;
                r_fill    <= r_fill + FILL_W'(w_len);
                r_bit_cnt <= r_bit_cnt + 64'(w_len);
            end else if (w_pop && w_full) begin
                r_buf      <= r_buf >> OUT_WIDTH;
                r_fill     <= r_fill - c_OUT_FILL;
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end else if (w_pop) begin
                r_buf           <= '0;
                r_fill          <= '0;
                r_beat_cnt      <= r_beat_cnt + 32'd1;
                r_flush_pending <= 1'b0;
                r_flush_done    <= 1'b1;
            end else if (r_flush_pending && (r_fill == '0)) begin
                r_flush_pending <= 1'b0;
                r_flush_done    <= 1'b1;
            end
            // A flush arriving with an accept lands after it: in_ready was
            // computed from the still-clear pending flag.
            if (flush && !r_flush_pending) begin
                r_flush_pending <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rr_logb_beat_aligner.sv
`default_nettype none
// Bench for rr_logb_beat_aligner at IN_WIDTH=200, OUT_WIDTH=512: a bit-queue
// reference model feeds a beat scoreboard; directed sequences cover stalls, flush and reset.
module tb_rr_logb_beat_aligner;
    localparam int IW = 200;
    localparam int OW = 512;
    localparam int LW = 8;
    localparam int BW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic [LW-1:0] in_len = '0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic [BW-1:0] out_bits;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          flush_done;
    logic [31:0]   beat_cnt;
    logic [63:0]   bit_cnt;

    always #5 clk = ~clk;

    rr_logb_beat_aligner #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_len(in_len), .in_ready(in_ready), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_bits(out_bits),
        .out_last(out_last), .out_ready(out_ready), .flush_done(flush_done),
        .beat_cnt(beat_cnt), .bit_cnt(bit_cnt)
    );

    typedef struct { logic [OW-1:0] data; int bits; logic last; } beat_t;
    typedef struct { int len; int exp_bits; } vec_t;

    beat_t         exp_q[$];
    bit            bitq[$];
    int            n_tests = 0;
    int            n_fail = 0;
    logic [63:0]   exp_bitcnt = '0;
    logic [OW-1:0] last_beat = '0;
    bit            rand_ready = 1'b0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [IW-1:0] rand200();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
        return r[IW-1:0];
    endfunction

    function automatic void model_push(input int len, input logic [IW-1:0] d);
        int n;
        n = (len > IW) ? IW : len;
        for (int i = 0; i < n; i++) bitq.push_back(d[i]);
        exp_bitcnt += 64'(n);
        while (bitq.size() >= OW) begin
            beat_t b;
            b.data = '0;
            for (int i = 0; i < OW; i++) b.data[i] = bitq.pop_front();
            b.bits = OW;
            b.last = 1'b0;
            exp_q.push_back(b);
        end
    endfunction

    function automatic void model_flush();
        beat_t b;
        if (bitq.size() != 0) begin
            b.data = '0;
            for (int i = 0; i < bitq.size(); i++) b.data[i] = bitq[i];
            b.bits = bitq.size();
            b.last = 1'b1;
            bitq.delete();
            exp_q.push_back(b);
        end
    endfunction

    // Scoreboard: every handshake pops and checks one modelled beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got beat %0h bits %0d want no beat", out_data, out_bits);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_data", out_data, b.data);
                chk("beat_bits", OW'(out_bits), OW'(b.bits));
                chk("beat_last", OW'(out_last), OW'(b.last));
            end
            last_beat = out_data;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int len, input logic [IW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = LW'(len);
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end else begin
            model_push(len, d);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats outstanding want 0", exp_q.size());
        end
        tick();
    endtask

    task automatic do_flush(input string name);
        int done_cnt;
        int done_at;
        int pad_at;
        bit pad_exp;
        done_cnt = 0;
        done_at  = -1;
        pad_at   = -1;
        pad_exp  = (bitq.size() != 0);
        model_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (flush_done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (out_valid && out_ready && out_last) pad_at = i;
            tick();
        end
        chk({name, "_done_count"}, OW'(done_cnt), OW'(1));
        if (pad_exp)
            chk({name, "_done_after_pad"}, OW'(done_at), OW'(pad_at + 1));
        else
            chk({name, "_done_no_pad"}, OW'(done_at), OW'(1));
    endtask

    initial begin
        vec_t          tbl[8];
        logic [IW-1:0] d0, d1, d2, d;
        logic [IW-1:0] ones;
        logic [63:0]   tbl_total;

        tbl[0] = '{0, 0};     tbl[1] = '{37, 37};   tbl[2] = '{200, 200};
        tbl[3] = '{1, 1};     tbl[4] = '{255, 200}; tbl[5] = '{37, 37};
        tbl[6] = '{200, 200}; tbl[7] = '{150, 150};
        ones = '1;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", OW'(out_valid), OW'(0));
        chk("rst_out_last", OW'(out_last), OW'(0));
        chk("rst_flush_done", OW'(flush_done), OW'(0));
        chk("rst_out_bits", OW'(out_bits), OW'(0));
        chk("rst_out_data", out_data, OW'(0));
        chk("rst_beat_cnt", OW'(beat_cnt), OW'(0));
        chk("rst_bit_cnt", OW'(bit_cnt), OW'(0));
        rst = 1'b0;
        chk("rst_in_ready", OW'(in_ready), OW'(1));

        // Three 200-bit words form one beat, 88 bits remain
        out_ready = 1'b1;
        d0 = rand200(); d1 = rand200(); d2 = rand200();
        send(200, d0); send(200, d1); send(200, d2);
        chk("latency_out_valid", OW'(out_valid), OW'(1));
        drain();
        chk("beat0_concat", last_beat, {d2[111:0], d1, d0});
        chk("beat0_beat_cnt", OW'(beat_cnt), OW'(1));
        chk("beat0_bit_cnt", OW'(bit_cnt), OW'(600));
        chk("beat0_idle_valid", OW'(out_valid), OW'(0));
        chk("beat0_in_ready", OW'(in_ready), OW'(1));

        do_flush("flush88");
        chk("flush88_data", last_beat, OW'(d2[199:112]));
        chk("flush88_beat_cnt", OW'(beat_cnt), OW'(2));

        do_flush("flush_empty");
        chk("flush_empty_beat_cnt", OW'(beat_cnt), OW'(2));

        // Backpressure: a full beat held for 10 cycles blocks input
        out_ready = 1'b0;
        send(200, rand200()); send(200, rand200()); send(200, rand200());
        d = rand200();
        in_valid = 1'b1; in_data = d; in_len = LW'(50);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", OW'(out_valid), OW'(1));
            chk("stall_data", out_data, exp_q[0].data);
            chk("stall_in_ready", OW'(in_ready), OW'(0));
            chk("stall_bit_cnt", OW'(bit_cnt), OW'(exp_bitcnt));
            tick();
        end
        out_ready = 1'b1;
        send(50, d);
        chk("release_in_ready", OW'(in_ready), OW'(1));
        chk("release_beat_cnt", OW'(beat_cnt), OW'(3));
        do_flush("flush_138");

        // Mixed lengths with 1s above in_len, random downstream ready
        rand_ready = 1'b1;
        tbl_total = bit_cnt;
        for (int i = 0; i < 8; i++) begin
            d = (rand200() & ~(ones << tbl[i].len)) | (ones << tbl[i].len);
            send(tbl[i].len, d);
            tbl_total += 64'(tbl[i].exp_bits);
            chk("vec_bit_cnt", OW'(bit_cnt), OW'(tbl_total));
        end
        do_flush("flush_mixed");
        rand_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        drain();
        chk("mixed_beat_cnt", OW'(beat_cnt), OW'(6));

        // Reset with 300 residual bits and a stalled padded beat
        out_ready = 1'b0;
        send(200, rand200()); send(100, rand200());
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("pend_pad_valid", OW'(out_valid), OW'(1));
        chk("pend_pad_last", OW'(out_last), OW'(1));
        chk("pend_pad_bits", OW'(out_bits), OW'(300));
        rst = 1'b1;
        tick(); tick();
        exp_q.delete();
        bitq.delete();
        exp_bitcnt = '0;
        chk("rst2_out_valid", OW'(out_valid), OW'(0));
        chk("rst2_out_last", OW'(out_last), OW'(0));
        chk("rst2_out_bits", OW'(out_bits), OW'(0));
        chk("rst2_out_data", out_data, OW'(0));
        chk("rst2_beat_cnt", OW'(beat_cnt), OW'(0));
        chk("rst2_bit_cnt", OW'(bit_cnt), OW'(0));
        rst = 1'b0;
        chk("rst2_in_ready", OW'(in_ready), OW'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst2_no_flush_done", OW'(flush_done), OW'(0));
            tick();
        end
        out_ready = 1'b1;
        d0 = rand200(); d1 = rand200(); d2 = rand200();
        send(200, d0); send(200, d1); send(112, d2);
        drain();
        chk("rst2_beat_concat", last_beat, {d2[111:0], d1, d0});
        chk("rst2_beat_cnt", OW'(beat_cnt), OW'(1));
        chk("rst2_bit_cnt", OW'(bit_cnt), OW'(512));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
